// File: rtl/waveform_sequencer.sv
// Note sequencer for the sine generator: queues {step, amp, dur} notes and plays them one by one.
// Optional inter-note silence is compiled in with `define SEQ_GAP_EN (GAP_CYCLES silent cycles).
module waveform_sequencer #(
    parameter int DEPTH      = 8,
    parameter int STEP_W     = 3,
    parameter int AMP_W      = 8,
    parameter int DUR_W      = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic [STEP_W-1:0]        note_step,
    input  logic [AMP_W-1:0]         note_amp,
    input  logic [DUR_W-1:0]         note_dur,
    input  logic                     start,
    input  logic                     stop,
    output logic [STEP_W-1:0]        gen_step,
    output logic [AMP_W-1:0]         gen_amp,
    output logic                     gen_run,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = STEP_W + AMP_W + DUR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY
`ifdef SEQ_GAP_EN
        , S_GAP
`endif
    } state_t;

    state_t               state_reg, state_next;
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [STEP_W-1:0]    gen_step_reg, gen_step_next;
    logic [AMP_W-1:0]     gen_amp_reg, gen_amp_next;
    logic                 gen_run_reg, gen_run_next;
    logic                 done_reg, done_next;
    logic                 busy_reg;
    logic [DUR_W-1:0]     dur_cnt_reg, dur_cnt_next;
    logic                 push, pop;

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [ENTRY_W-1:0]   head;
    logic [STEP_W-1:0]    head_step;
    logic [AMP_W-1:0]     head_amp;
    logic [DUR_W-1:0]     head_dur;

`ifdef SEQ_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
`else
    // GAP_CYCLES only matters for the gap build; keep it referenced so the parameter list is uniform.
    if (GAP_CYCLES < 0) begin : g_gap_unused
    end
`endif

    assign note_ready = (count_reg < CNT_W'(DEPTH));
    assign push       = note_valid && note_ready;

    // Head is read combinationally so FETCH can load the generator in the same cycle it pops.
    assign head      = mem[rd_ptr_reg];
    assign head_step = head[ENTRY_W-1 -: STEP_W];
    assign head_amp  = head[DUR_W +: AMP_W];
    assign head_dur  = head[DUR_W-1:0];

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= {note_step, note_amp, note_dur};
        end
    end

    always_comb begin
        state_next    = state_reg;
        gen_step_next = gen_step_reg;
        gen_amp_next  = gen_amp_reg;
        gen_run_next  = 1'b0;
        done_next     = 1'b0;
        dur_cnt_next  = dur_cnt_reg;
        pop           = 1'b0;
`ifdef SEQ_GAP_EN
        gap_cnt_next  = gap_cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start && (count_reg != '0)) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                pop           = (count_reg != '0);
                gen_step_next = head_step;
                gen_amp_next  = head_amp;
                dur_cnt_next  = (head_dur == '0) ? DUR_W'(1) : head_dur;
                gen_run_next  = 1'b1;
                state_next    = S_PLAY;
            end
            S_PLAY: begin
                gen_run_next = 1'b1;
                dur_cnt_next = dur_cnt_reg - DUR_W'(1);
                if (dur_cnt_reg == DUR_W'(1)) begin
                    gen_run_next = 1'b0;
                    if (count_reg != '0) begin
`ifdef SEQ_GAP_EN
                        if (GAP_CYCLES > 0) begin
                            state_next   = S_GAP;
                            gap_cnt_next = GAP_W'(GAP_CYCLES);
                            gen_amp_next = '0;
                        end else begin
                            state_next = S_FETCH;
                        end
`else
                        state_next = S_FETCH;
`endif
                    end else begin
                        state_next   = S_IDLE;
                        gen_amp_next = '0;
                        done_next    = 1'b1;
                    end
                end
            end
`ifdef SEQ_GAP_EN
            S_GAP: begin
                gen_amp_next = '0;
                gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                if (gap_cnt_reg <= GAP_W'(1)) begin
                    state_next = S_FETCH;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort wins over everything; queued notes stay, the current one is dropped.
        if (stop) begin
            state_next   = S_IDLE;
            gen_run_next = 1'b0;
            gen_amp_next = '0;
            done_next    = 1'b0;
            pop          = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            gen_step_reg <= '0;
            gen_amp_reg  <= '0;
            gen_run_reg  <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            dur_cnt_reg  <= '0;
`ifdef SEQ_GAP_EN
            gap_cnt_reg  <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            gen_step_reg <= gen_step_next;
            gen_amp_reg  <= gen_amp_next;
            gen_run_reg  <= gen_run_next;
            done_reg     <= done_next;
            busy_reg     <= (state_next != S_IDLE);
            dur_cnt_reg  <= dur_cnt_next;
`ifdef SEQ_GAP_EN
            gap_cnt_reg  <= gap_cnt_next;
`endif
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign gen_step   = gen_step_reg;
    assign gen_amp    = gen_amp_reg;
    assign gen_run    = gen_run_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign fifo_count = count_reg;

endmodule
